// File: rtl/ins_cache_assoc.sv
// ins_cache_assoc: blocking set-associative instruction cache with round-robin replacement, flush and fetch cancel
module ins_cache_assoc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 2,
  parameter int SET_WIDTH   = 4,
  parameter int WAY_WIDTH   = 1
) (
  input  logic                          Sys_clk,
  input  logic                          Sys_rst,
  input  logic                          Sys_rdy,
  input  logic                          IFIC_en,
  input  logic [ADDR_WIDTH-1:0]         IFIC_addr,
  input  logic                          IF_clear,
  input  logic                          IC_flush,
  output logic                          ICIF_en,
  output logic [31:0]                   ICIF_data,
  output logic                          ICMC_en,
  output logic [ADDR_WIDTH-1:0]         ICMC_addr,
  input  logic                          MCIC_en,
  input  logic [32*(1<<BLOCK_WIDTH)-1:0] MCIC_block
);
  localparam int SETS = 1 << SET_WIDTH;
  localparam int WAYS = 1 << WAY_WIDTH;
  localparam int LW   = BLOCK_WIDTH + 2;
  localparam int TW   = ADDR_WIDTH - SET_WIDTH - LW;
  localparam logic [ADDR_WIDTH-1:0] ALIGN = {{(ADDR_WIDTH-LW){1'b1}}, {LW{1'b0}}};

  typedef enum logic {IDLE, MISS} state_t;
  state_t state, state_n;

  logic [WAYS-1:0]            valid  [SETS];
  logic [TW-1:0]              tags   [SETS][WAYS];
  logic [32*(1<<BLOCK_WIDTH)-1:0] blocks [SETS][WAYS];
  logic [WAY_WIDTH-1:0]       rr     [SETS];

  logic [BLOCK_WIDTH-1:0] off_q;
  logic [SET_WIDTH-1:0]   idx_q;
  logic [TW-1:0]          tag_q;
  logic [WAY_WIDTH-1:0]   vic_q;
  logic                   cancel;

  logic [BLOCK_WIDTH-1:0] off;
  logic [SET_WIDTH-1:0]   idx;
  logic [TW-1:0]          tag;
  logic                   hit_any, lookup, hit, miss, fill;
  logic [WAY_WIDTH-1:0]   hit_way;
  logic                   icif_en_n, icmc_en_n;
  logic [31:0]            icif_data_n;
  logic [ADDR_WIDTH-1:0]  icmc_addr_n;

  assign off = IFIC_addr[LW-1:2];
  assign idx = IFIC_addr[SET_WIDTH+LW-1:LW];
  assign tag = IFIC_addr[ADDR_WIDTH-1:SET_WIDTH+LW];

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
  end

  // A flush in the lookup cycle forces a miss; a clear drops the lookup entirely
  assign lookup = Sys_rdy && state == IDLE && IFIC_en && !IF_clear;
  assign hit    = lookup && hit_any && !IC_flush;
  assign miss   = lookup && !hit;
  assign fill   = Sys_rdy && state == MISS && MCIC_en;

  // State register
  always_ff @(posedge Sys_clk or negedge Sys_rst)
    if (!Sys_rst) state <= IDLE;
    else state <= state_n;

  // Next-state logic
  always_comb state_n = miss ? MISS : fill ? IDLE : state;

  // Next values of the registered outputs
  always_comb begin
    icif_en_n   = Sys_rdy ? (hit || (fill && !cancel && !IF_clear)) : ICIF_en;
    icif_data_n = hit ? blocks[idx][hit_way][32*off +: 32] : fill ? MCIC_block[32*off_q +: 32] : ICIF_data;
    icmc_en_n   = miss ? 1'b1 : fill ? 1'b0 : ICMC_en;
    icmc_addr_n = miss ? (IFIC_addr & ALIGN) : ICMC_addr;
  end

  // Output registers, miss context, cancel flag, valid bits and replacement pointers
  always_ff @(posedge Sys_clk or negedge Sys_rst)
    if (!Sys_rst) begin
      ICIF_en   <= 1'b0;
      ICIF_data <= '0;
      ICMC_en   <= 1'b0;
      ICMC_addr <= '0;
      cancel    <= 1'b0;
      off_q     <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
      vic_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      ICIF_en   <= icif_en_n;
      ICIF_data <= icif_data_n;
      ICMC_en   <= icmc_en_n;
      ICMC_addr <= icmc_addr_n;
      if (miss) begin
        off_q <= off;
        idx_q <= idx;
        tag_q <= tag;
        vic_q <= rr[idx];
      end
      if (fill) cancel <= 1'b0;
      else if (Sys_rdy && state == MISS && IF_clear) cancel <= 1'b1;
      if (Sys_rdy && IC_flush)
        for (int s = 0; s < SETS; s++) valid[s] <= '0;
      if (fill) begin
        valid[idx_q][vic_q] <= 1'b1;
        rr[idx_q]           <= rr[idx_q] + 1'b1;
      end
    end

  // Line payload and tag storage need no reset; valid bits gate their use
  always_ff @(posedge Sys_clk)
    if (fill) begin
      blocks[idx_q][vic_q] <= MCIC_block;
      tags[idx_q][vic_q]   <= tag_q;
    end
endmodule
